// File: rtl/fsic_io_serdes_pkg.sv
// Shared FSIC IO serdes definitions: RX FSM encoding and the TX/RX start phase.
package fsic_io_serdes_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_PRIME = 2'd1,
        RX_RUN   = 2'd2
    } rx_state_e;

    // TX and RX both begin a link at the last bit slot of a word.
    function automatic int unsigned start_phase(input int unsigned ratio);
        return ratio - 1;
    endfunction

endpackage

// File: rtl/fsic_io_serdes_rx_if.sv
// Word-side valid/ready interface of the FSIC IO serdes RX lane.
interface fsic_io_serdes_rx_if #(
    parameter int unsigned pCLK_RATIO   = 4,
    parameter int unsigned RxFIFO_DEPTH = 4
);
    localparam int unsigned LW = $clog2(RxFIFO_DEPTH) + 1;

    logic [pCLK_RATIO-1:0] rxdata_out;
    logic                  rxdata_valid;
    logic                  rxdata_ready;
    logic                  rx_overflow;
    logic [LW-1:0]         rx_fifo_level;

    modport master (
        output rxdata_out,
        output rxdata_valid,
        output rx_overflow,
        output rx_fifo_level,
        input  rxdata_ready
    );

    modport slave (
        input  rxdata_out,
        input  rxdata_valid,
        input  rx_overflow,
        input  rx_fifo_level,
        output rxdata_ready
    );
endinterface

// File: rtl/fsic_io_serdes_rx_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a registered head word.
module fsic_io_serdes_rx_fifo #(
    parameter int unsigned W     = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [W-1:0]               wdata_i,
    input  logic                       pop_i,
    output logic [W-1:0]               rdata_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
    logic [W-1:0]  rdata_q, rdata_d;
    logic          do_push, do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign level_o = wr_q - rd_q;
    assign rdata_o = rdata_q;

    // Pop frees a slot first, so a push into a full FIFO succeeds when popped together.
    always_comb begin
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        rd_d    = rd_q + {{AW{1'b0}}, do_pop};
        wr_d    = wr_q + {{AW{1'b0}}, do_push};
        rdata_d = rdata_q;
        if (rd_d == wr_d)
            rdata_d = rdata_q;
        else if (do_push && (rd_d == wr_q))
            rdata_d = wdata_i;
        else
            rdata_d = mem_q[rd_d[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            rdata_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wr_q[AW-1:0]] <= wdata_i;
    end
endmodule

// File: rtl/fsic_io_serdes_rx.sv
// FSIC IO serdes RX lane: serial-to-parallel deserializer, link FSM and word FIFO.
module fsic_io_serdes_rx
    import fsic_io_serdes_pkg::*;
#(
    parameter int unsigned pCLK_RATIO   = 4,
    parameter int unsigned RxFIFO_DEPTH = 4
) (
    input  logic                  ioclk,
    input  logic                  axis_rst_n,
    input  logic                  rx_en,
    input  logic                  Serial_Data_In,
    input  logic                  rx_bitslip,
    fsic_io_serdes_rx_if.master   rx
);
    localparam int unsigned   PW       = $clog2(pCLK_RATIO);
    localparam logic [PW-1:0] START_PH = PW'(start_phase(pCLK_RATIO));

    rx_state_e             state_q, state_d;
    logic [PW-1:0]         phase_q, phase_d;
    logic [pCLK_RATIO-1:0] shreg_q, shreg_d;
    logic [pCLK_RATIO-1:0] word_q, word_d;
    logic                  push_q, push_d;
    logic                  ovf_q, ovf_d;
    logic                  fifo_empty, fifo_full;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        shreg_d = shreg_q;
        word_d  = word_q;
        push_d  = 1'b0;
        if (!rx_en) begin
            state_d = RX_IDLE;
            phase_d = START_PH;
        end else begin
            unique case (state_q)
                RX_IDLE: state_d = RX_PRIME;
                RX_PRIME: begin
                    shreg_d[START_PH] = Serial_Data_In;
                    phase_d           = '0;
                    state_d           = RX_RUN;
                end
                RX_RUN: begin
                    // A bitslip rewrites the same slot next cycle, delaying the boundary.
                    shreg_d[phase_q] = Serial_Data_In;
                    if (!rx_bitslip) begin
                        phase_d = phase_q + 1'b1;
                        if (phase_q == START_PH) begin
                            push_d = 1'b1;
                            word_d = shreg_d;
                        end
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    assign ovf_d = ovf_q | (push_q & fifo_full & ~rx.rxdata_ready);

    always_ff @(posedge ioclk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q <= RX_IDLE;
            phase_q <= START_PH;
            shreg_q <= '0;
            word_q  <= '0;
            push_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            shreg_q <= shreg_d;
            word_q  <= word_d;
            push_q  <= push_d;
            ovf_q   <= ovf_d;
        end
    end

    fsic_io_serdes_rx_fifo #(
        .W     (pCLK_RATIO),
        .DEPTH (RxFIFO_DEPTH)
    ) u_fifo (
        .clk     (ioclk),
        .rst_n   (axis_rst_n),
        .push_i  (push_q),
        .wdata_i (word_q),
        .pop_i   (rx.rxdata_ready),
        .rdata_o (rx.rxdata_out),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .level_o (rx.rx_fifo_level)
    );

    assign rx.rxdata_valid = ~fifo_empty;
    assign rx.rx_overflow  = ovf_q;
endmodule
